// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path: FSM states, Len/Par encodings, RD field layout.
// Imported by uart_rx_sampler and uart_rx_engine.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        SHIFT  = 3'd2,
        PARITY = 3'd3,
        STOP1  = 3'd4,
        STOP2  = 3'd5,
        WAIT   = 3'd6
    } rx_state_e;

    localparam logic [1:0] LEN_5 = 2'b00;
    localparam logic [1:0] LEN_6 = 2'b01;
    localparam logic [1:0] LEN_7 = 2'b10;
    localparam logic [1:0] LEN_8 = 2'b11;

    localparam logic [1:0] PAR_ODD   = 2'b00;
    localparam logic [1:0] PAR_EVEN  = 2'b01;
    localparam logic [1:0] PAR_SPACE = 2'b10;
    localparam logic [1:0] PAR_MARK  = 2'b11;

    localparam int RD_W  = 11;
    localparam int RD_BI = 10;
    localparam int RD_FE = 9;
    localparam int RD_PE = 8;

    // Index of the last data bit for a given Len code (5..8 bits -> 4..7).
    function automatic logic [2:0] last_bit_idx(input logic [1:0] len);
        return 3'd4 + {1'b0, len};
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// RxD synchroniser, oversample bit counter and 3-sample majority vote.
// Latency: SYNC_STAGES Clk on RxD; strobes are combinational on the CE tick. No backpressure.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int OVS         = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic Clk,
    input  logic Rst,
    input  logic RxD,
    input  logic ce_ovs,
    input  logic run,
    output logic rxd_sync,
    output logic bit_valid,
    output logic bit_val,
    output logic bit_end
);

    localparam int CW = $clog2(OVS);
    localparam logic [CW-1:0] VOTE_FIRST = CW'(OVS / 2 - 1);
    localparam logic [CW-1:0] VOTE_LAST  = CW'(OVS / 2 + 1);
    localparam logic [CW-1:0] CNT_MAX    = CW'(OVS - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2:0]             vote_q, vote_d;
    logic                   tick;

    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], RxD};
        rxd_sync  = sync_q[SYNC_STAGES-1];
        tick      = run && ce_ovs;
        vote_d    = vote_q;
        cnt_d     = cnt_q;
        bit_valid = tick && (cnt_q == VOTE_LAST);
        bit_end   = tick && (cnt_q == CNT_MAX);
        // The third sample is still in flight on the decision tick, so vote on it directly.
        bit_val   = (vote_q[1] & vote_q[0]) | (vote_q[1] & rxd_sync) | (vote_q[0] & rxd_sync);

        if (tick && (cnt_q >= VOTE_FIRST) && (cnt_q <= VOTE_LAST)) begin
            vote_d = {vote_q[1:0], rxd_sync};
        end

        if (!run) begin
            cnt_d = '0;
        end else if (ce_ovs) begin
            cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            sync_q <= '1;
            cnt_q  <= '0;
            vote_q <= 3'b111;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            vote_q <= vote_d;
        end
    end

endmodule

// File: rtl/uart_rx_engine.sv
// UART receive FSM: start/false-start, 5-8 data bits, optional parity, 1/2 stop bits -> one tagged word per frame.
// Latency: WE_RHR one Clk after the final stop-bit decision tick. No backpressure; the holding FIFO must accept every word.
// Break detection (BI) is built only when UART_RX_BREAK_DET_EN is defined; otherwise BI is tied 0.
module uart_rx_engine
    import uart_pkg::*;
#(
    parameter int OVS         = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic            CE_Ovs,
    input  logic [1:0]      Len,
    input  logic            NumStop,
    input  logic            ParEn,
    input  logic [1:0]      Par,
    input  logic            RxD,
    output logic [RD_W-1:0] RD,
    output logic            WE_RHR,
    output logic            RxIdle,
    output logic            RxStart,
    output logic            RxShift,
    output logic            RxParity,
    output logic            RxStop,
    output logic            RxWait,
    output logic            RxError
);

    rx_state_e       state_q, state_d;
    logic [1:0]      len_q, len_d;
    logic            num_stop_q, num_stop_d;
    logic            par_en_q, par_en_d;
    logic [1:0]      par_q, par_d;
    logic [7:0]      data_q, data_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic            par_acc_q, par_acc_d;
    logic            pe_q, pe_d;
    logic            fe_q, fe_d;
    logic [RD_W-1:0] rd_q, rd_d;
    logic            we_q, we_d;
    logic            err_q, err_d;
`ifdef UART_RX_BREAK_DET_EN
    logic            brk_q, brk_d;
    logic            par_bit_q, par_bit_d;
    logic            stop_brk;
    logic            brk_fin;
`endif

    logic            run;
    logic            rxd_sync;
    logic            bit_valid;
    logic            bit_val;
    logic            bit_end;
    logic            final_stop;
    logic            fe_fin;
    logic [RD_W-1:0] word;

    assign run = (state_q != IDLE) && (state_q != WAIT);

    uart_rx_sampler #(
        .OVS         (OVS),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sampler (
        .Clk       (Clk),
        .Rst       (Rst),
        .RxD       (RxD),
        .ce_ovs    (CE_Ovs),
        .run       (run),
        .rxd_sync  (rxd_sync),
        .bit_valid (bit_valid),
        .bit_val   (bit_val),
        .bit_end   (bit_end)
    );

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        num_stop_d = num_stop_q;
        par_en_d   = par_en_q;
        par_d      = par_q;
        data_d     = data_q;
        bit_idx_d  = bit_idx_q;
        par_acc_d  = par_acc_q;
        pe_d       = pe_q;
        fe_d       = fe_q;
        rd_d       = rd_q;
        err_d      = err_q;
        we_d       = 1'b0;
        final_stop = 1'b0;
        fe_fin     = fe_q | ~bit_val;
        word       = {1'b0, fe_fin, pe_q, data_q};
`ifdef UART_RX_BREAK_DET_EN
        brk_d      = brk_q;
        par_bit_d  = par_bit_q;
        stop_brk   = (data_q == 8'h00) && (!par_en_q || !par_bit_q) && !bit_val;
        brk_fin    = (state_q == STOP1) ? stop_brk : brk_q;
        if (brk_fin) begin
            word = '0;
            word[RD_BI] = 1'b1;
            word[RD_FE] = 1'b1;
        end
`endif

        case (state_q)
            IDLE: begin
                if (CE_Ovs && !rxd_sync) begin
                    state_d = START;
                end
            end
            START: begin
                if (bit_valid) begin
                    if (bit_val) begin
                        state_d = IDLE;
                    end else begin
                        // Frame format is frozen here so mid-frame register writes cannot corrupt it.
                        len_d      = Len;
                        num_stop_d = NumStop;
                        par_en_d   = ParEn;
                        par_d      = Par;
                        data_d     = 8'h00;
                        bit_idx_d  = 3'd0;
                        par_acc_d  = 1'b0;
                        pe_d       = 1'b0;
                        fe_d       = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
                        brk_d      = 1'b0;
                        par_bit_d  = 1'b0;
`endif
                    end
                end else if (bit_end) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_valid) begin
                    data_d[bit_idx_q] = bit_val;
                    par_acc_d         = par_acc_q ^ bit_val;
                end
                if (bit_end) begin
                    if (bit_idx_q == last_bit_idx(len_q)) begin
                        state_d = par_en_q ? PARITY : STOP1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (bit_valid) begin
                    // Odd expects an overall XOR of 1 and even of 0, i.e. an error when it equals Par[0].
                    pe_d = par_q[1] ? (bit_val != par_q[0]) : ((par_acc_q ^ bit_val) == par_q[0]);
`ifdef UART_RX_BREAK_DET_EN
                    par_bit_d = bit_val;
`endif
                end
                if (bit_end) begin
                    state_d = STOP1;
                end
            end
            STOP1: begin
                if (bit_valid) begin
                    fe_d = fe_q | ~bit_val;
`ifdef UART_RX_BREAK_DET_EN
                    brk_d = stop_brk;
`endif
                    final_stop = !num_stop_q;
                end else if (bit_end) begin
                    state_d = STOP2;
                end
            end
            STOP2: begin
                final_stop = bit_valid;
            end
            WAIT: begin
                if (CE_Ovs && rxd_sync) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (final_stop) begin
            we_d    = 1'b1;
            rd_d    = word;
            err_d   = |word[RD_BI:RD_PE];
            state_d = bit_val ? IDLE : WAIT;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= IDLE;
            len_q      <= LEN_5;
            num_stop_q <= 1'b0;
            par_en_q   <= 1'b0;
            par_q      <= PAR_ODD;
            data_q     <= 8'h00;
            bit_idx_q  <= 3'd0;
            par_acc_q  <= 1'b0;
            pe_q       <= 1'b0;
            fe_q       <= 1'b0;
            rd_q       <= '0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            brk_q      <= 1'b0;
            par_bit_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            num_stop_q <= num_stop_d;
            par_en_q   <= par_en_d;
            par_q      <= par_d;
            data_q     <= data_d;
            bit_idx_q  <= bit_idx_d;
            par_acc_q  <= par_acc_d;
            pe_q       <= pe_d;
            fe_q       <= fe_d;
            rd_q       <= rd_d;
            we_q       <= we_d;
            err_q      <= err_d;
`ifdef UART_RX_BREAK_DET_EN
            brk_q      <= brk_d;
            par_bit_q  <= par_bit_d;
`endif
        end
    end

    assign RD       = rd_q;
    assign WE_RHR   = we_q;
    assign RxError  = err_q;
    assign RxIdle   = (state_q == IDLE);
    assign RxStart  = (state_q == START);
    assign RxShift  = (state_q == SHIFT);
    assign RxParity = (state_q == PARITY);
    assign RxStop   = (state_q == STOP1) || (state_q == STOP2);
    assign RxWait   = (state_q == WAIT);

endmodule

// File: tb/tb_uart_rx_engine.sv
// Bench for uart_rx_engine: directed frames plus randomized frames checked against a frame-level reference model.
module tb_uart_rx_engine;

    localparam int OVS = 16;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        CE_Ovs = 1'b1;
    logic [1:0]  Len = 2'b11;
    logic        NumStop = 1'b0;
    logic        ParEn = 1'b0;
    logic [1:0]  Par = 2'b00;
    logic        RxD = 1'b1;
    logic [10:0] RD;
    logic        WE_RHR, RxIdle, RxStart, RxShift, RxParity, RxStop, RxWait, RxError;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int tick_div = 1;
    int ce_phase = 0;
    int onehot_err = 0;
    bit mon_en = 1'b0;
    logic [10:0] wq[$];
    int          wt[$];

    uart_rx_engine #(.OVS(OVS), .SYNC_STAGES(2)) dut (
        .Clk(Clk), .Rst(Rst), .CE_Ovs(CE_Ovs), .Len(Len), .NumStop(NumStop),
        .ParEn(ParEn), .Par(Par), .RxD(RxD), .RD(RD), .WE_RHR(WE_RHR),
        .RxIdle(RxIdle), .RxStart(RxStart), .RxShift(RxShift), .RxParity(RxParity),
        .RxStop(RxStop), .RxWait(RxWait), .RxError(RxError)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    always @(negedge Clk) begin
        if (WE_RHR === 1'b1) begin
            wq.push_back(RD);
            wt.push_back(cyc);
        end
        if (mon_en && $countones({RxIdle, RxStart, RxShift, RxParity, RxStop, RxWait}) != 1)
            onehot_err++;
    end

    task automatic step();
        @(posedge Clk);
        #1;
        ce_phase = (ce_phase + 1) % tick_div;
        CE_Ovs = (ce_phase == 0);
    endtask

    task automatic hold(input logic v, input int ticks);
        RxD = v;
        repeat (ticks * tick_div) step();
    endtask

    task automatic send_frame(input int nbits, input logic [7:0] data, input bit has_par,
                              input logic pbit, input int nstop, input logic s1, input logic s2);
        hold(1'b0, OVS);
        for (int i = 0; i < nbits; i++) hold(data[i], OVS);
        if (has_par) hold(pbit, OVS);
        hold(s1, OVS);
        if (nstop == 2) hold(s2, OVS);
    endtask

    task automatic set_cfg(input int nbits, input bit has_par, input logic [1:0] pm, input int nstop);
        Len = 2'(nbits - 5);
        ParEn = has_par;
        Par = pm;
        NumStop = (nstop == 2);
    endtask

    function automatic logic good_par(input logic [1:0] pm, input logic [7:0] d);
        int ones = $countones(d);
        case (pm)
            2'b00:   return (ones % 2 == 0);
            2'b01:   return (ones % 2 == 1);
            2'b10:   return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    // Frame-level expectation: what the received word should be given the bits put on the line.
    function automatic logic [10:0] model_rd(input int nbits, input logic [7:0] data, input bit has_par,
                                             input logic pbit, input logic [1:0] pm, input int nstop,
                                             input logic s1, input logic s2);
        logic [7:0] d;
        logic pe, fe;
        int ones;
        d = data & 8'((1 << nbits) - 1);
        ones = $countones(d);
        pe = 1'b0;
        if (has_par) begin
            if (pm[1]) pe = (pbit != pm[0]);
            else pe = (((ones + int'(pbit)) % 2) != ((pm == 2'b00) ? 1 : 0));
        end
        fe = !s1 || (nstop == 2 && !s2);
`ifdef UART_RX_BREAK_DET_EN
        if (d == 8'h00 && (!has_par || !pbit) && !s1) return 11'h600;
`endif
        return {1'b0, fe, pe, d};
    endfunction

    task automatic test_reset();
        Rst = 1'b1; RxD = 1'b1;
        repeat (3) step();
        total++; if (RD !== 11'h000) begin bad++; $display("FAIL reset_rd got=%h want=000", RD); end
        total++; if (WE_RHR !== 1'b0) begin bad++; $display("FAIL reset_we got=%b want=0", WE_RHR); end
        total++; if (RxError !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", RxError); end
        total++; if (RxIdle !== 1'b1) begin bad++; $display("FAIL reset_idle got=%b want=1", RxIdle); end
        total++;
        if ({RxStart, RxShift, RxParity, RxStop, RxWait} !== 5'b0) begin
            bad++; $display("FAIL reset_flags got=%b want=00000", {RxStart, RxShift, RxParity, RxStop, RxWait});
        end
        Rst = 1'b0;
        hold(1'b1, 4);
        mon_en = 1'b1;
    endtask

    task automatic test_back_to_back();
        set_cfg(8, 0, 2'b00, 1);
        wq.delete(); wt.delete();
        send_frame(8, 8'h77, 0, 1'b0, 1, 1'b1, 1'b1);
        send_frame(8, 8'h55, 0, 1'b0, 1, 1'b1, 1'b1);
        hold(1'b1, 3 * OVS);
        total++;
        if (wq.size() != 2) begin
            bad++; $display("FAIL b2b_count got=%0d want=2", wq.size());
        end else begin
            total++; if (wq[0] !== 11'h077) begin bad++; $display("FAIL b2b_rd0 got=%h want=077", wq[0]); end
            total++; if (wq[1] !== 11'h055) begin bad++; $display("FAIL b2b_rd1 got=%h want=055", wq[1]); end
            total++; if (wt[1] - wt[0] != 160) begin bad++; $display("FAIL b2b_gap got=%0d want=160", wt[1] - wt[0]); end
        end
        total++; if (RxError !== 1'b0) begin bad++; $display("FAIL b2b_err got=%b want=0", RxError); end
    endtask

    task automatic test_parity();
        set_cfg(7, 1, 2'b00, 1);
        wq.delete();
        send_frame(7, 8'h5A, 1, 1'b1, 1, 1'b1, 1'b1);
        hold(1'b1, OVS);
        send_frame(7, 8'h5A, 1, 1'b0, 1, 1'b1, 1'b1);
        hold(1'b1, 2 * OVS);
        total++;
        if (wq.size() != 2) begin
            bad++; $display("FAIL par_count got=%0d want=2", wq.size());
        end else begin
            total++; if (wq[0] !== 11'h05A) begin bad++; $display("FAIL par_odd_ok got=%h want=05A", wq[0]); end
            total++; if (wq[1] !== 11'h15A) begin bad++; $display("FAIL par_err got=%h want=15A", wq[1]); end
        end
        total++; if (RxError !== 1'b1) begin bad++; $display("FAIL par_rxerror got=%b want=1", RxError); end
    endtask

    task automatic test_false_start_glitch();
        logic [7:0] d = 8'h33;
        set_cfg(8, 0, 2'b00, 1);
        wq.delete();
        hold(1'b0, 5);
        total++; if (RxStart !== 1'b1) begin bad++; $display("FAIL fs_start got=%b want=1", RxStart); end
        hold(1'b0, 1);
        hold(1'b1, 20);
        total++; if (RxIdle !== 1'b1) begin bad++; $display("FAIL fs_idle got=%b want=1", RxIdle); end
        total++; if (wq.size() != 0) begin bad++; $display("FAIL fs_nowrite got=%0d want=0", wq.size()); end
        hold(1'b0, OVS);
        for (int i = 0; i < 8; i++) begin
            if (i == 2) begin
                hold(d[i], 8); hold(~d[i], 1); hold(d[i], 7);
            end else begin
                hold(d[i], OVS);
            end
        end
        hold(1'b1, 2 * OVS);
        total++;
        if (wq.size() != 1) begin
            bad++; $display("FAIL glitch_count got=%0d want=1", wq.size());
        end else begin
            total++; if (wq[0] !== 11'h033) begin bad++; $display("FAIL glitch_rd got=%h want=033", wq[0]); end
        end
    endtask

    task automatic test_stop2_error();
        set_cfg(8, 0, 2'b00, 2);
        wq.delete();
        send_frame(8, 8'hA5, 0, 1'b0, 2, 1'b1, 1'b0);
        hold(1'b0, 2 * OVS);
        total++; if (RxWait !== 1'b1) begin bad++; $display("FAIL s2_wait got=%b want=1", RxWait); end
        total++;
        if (wq.size() != 1) begin
            bad++; $display("FAIL s2_count got=%0d want=1", wq.size());
        end else begin
            total++; if (wq[0] !== 11'h2A5) begin bad++; $display("FAIL s2_rd got=%h want=2A5", wq[0]); end
        end
        total++; if (RxError !== 1'b1) begin bad++; $display("FAIL s2_err got=%b want=1", RxError); end
        hold(1'b1, OVS);
        total++; if (RxIdle !== 1'b1) begin bad++; $display("FAIL s2_idle got=%b want=1", RxIdle); end
    endtask

    task automatic test_break();
        logic [10:0] exp_brk;
`ifdef UART_RX_BREAK_DET_EN
        exp_brk = 11'h600;
`else
        exp_brk = 11'h200;
`endif
        set_cfg(8, 0, 2'b00, 1);
        wq.delete();
        hold(1'b0, 30 * OVS);
        total++; if (RxWait !== 1'b1) begin bad++; $display("FAIL brk_wait got=%b want=1", RxWait); end
        hold(1'b1, 2 * OVS);
        total++; if (RxIdle !== 1'b1) begin bad++; $display("FAIL brk_idle got=%b want=1", RxIdle); end
        total++;
        if (wq.size() != 1) begin
            bad++; $display("FAIL brk_count got=%0d want=1", wq.size());
        end else begin
            total++; if (wq[0] !== exp_brk) begin bad++; $display("FAIL brk_rd got=%h want=%h", wq[0], exp_brk); end
        end
    endtask

    task automatic test_reset_mid_frame();
        set_cfg(5, 1, 2'b11, 1);
        wq.delete();
        hold(1'b0, OVS);
        hold(1'b1, 2 * OVS);
        total++; if (RxShift !== 1'b1) begin bad++; $display("FAIL rst_mid_shift got=%b want=1", RxShift); end
        Rst = 1'b1;
        step();
        total++; if (RxIdle !== 1'b1) begin bad++; $display("FAIL rst_mid_idle got=%b want=1", RxIdle); end
        Rst = 1'b0;
        hold(1'b1, 6 * OVS);
        total++; if (wq.size() != 0) begin bad++; $display("FAIL rst_mid_nowrite got=%0d want=0", wq.size()); end
        send_frame(5, 8'h1F, 1, 1'b1, 1, 1'b1, 1'b1);
        hold(1'b1, 2 * OVS);
        total++;
        if (wq.size() != 1) begin
            bad++; $display("FAIL rst_next_count got=%0d want=1", wq.size());
        end else begin
            total++; if (wq[0] !== 11'h01F) begin bad++; $display("FAIL rst_next_rd got=%h want=01F", wq[0]); end
        end
    endtask

    task automatic test_ce_hold();
        logic [7:0] d;
        logic [10:0] exp;
        d = 8'($urandom);
        tick_div = 3; ce_phase = 0;
        set_cfg(8, 1, 2'b01, 1);
        wq.delete();
        send_frame(8, d, 1, good_par(2'b01, d), 1, 1'b1, 1'b1);
        hold(1'b1, 2 * OVS);
        exp = model_rd(8, d, 1, good_par(2'b01, d), 2'b01, 1, 1'b1, 1'b1);
        total++;
        if (wq.size() != 1) begin
            bad++; $display("FAIL ce_count got=%0d want=1", wq.size());
        end else begin
            total++; if (wq[0] !== exp) begin bad++; $display("FAIL ce_rd got=%h want=%h", wq[0], exp); end
        end
        tick_div = 1; ce_phase = 0; CE_Ovs = 1'b1;
    endtask

    task automatic test_random();
        logic [10:0] exp_q[$];
        int nbits, nstop;
        bit has_par;
        logic [1:0] pm;
        logic [7:0] d;
        logic pbit, s1, s2, fin;
        wq.delete();
        for (int n = 0; n < 16; n++) begin
            nbits = $urandom_range(5, 8);
            nstop = $urandom_range(1, 2);
            has_par = $urandom_range(0, 1);
            pm = 2'($urandom_range(0, 3));
            d = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            pbit = good_par(pm, d & 8'((1 << nbits) - 1)) ^ ($urandom_range(0, 3) == 0);
            s1 = ($urandom_range(0, 4) != 0);
            s2 = ($urandom_range(0, 4) != 0);
            set_cfg(nbits, has_par, pm, nstop);
            send_frame(nbits, d, has_par, pbit, nstop, s1, s2);
            exp_q.push_back(model_rd(nbits, d, has_par, pbit, pm, nstop, s1, s2));
            fin = (nstop == 2) ? s2 : s1;
            if (!fin) hold(1'b1, OVS);
            else hold(1'b1, $urandom_range(0, 2) * OVS);
        end
        hold(1'b1, 2 * OVS);
        total++;
        if (wq.size() != exp_q.size()) begin
            bad++; $display("FAIL rand_count got=%0d want=%0d", wq.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                total++;
                if (wq[i] !== exp_q[i]) begin bad++; $display("FAIL rand_rd[%0d] got=%h want=%h", i, wq[i], exp_q[i]); end
            end
            total++;
            if (RxError !== (|exp_q[exp_q.size()-1][10:8])) begin
                bad++; $display("FAIL rand_rxerror got=%b want=%b", RxError, |exp_q[exp_q.size()-1][10:8]);
            end
        end
    endtask

    task automatic test_onehot();
        total++;
        if (onehot_err != 0) begin bad++; $display("FAIL flags_onehot violations=%0d want=0", onehot_err); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_parity();
        test_false_start_glitch();
        test_stop2_error();
        test_break();
        test_reset_mid_frame();
        test_ce_hold();
        test_random();
        test_onehot();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
